// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   - FSM state encodings for the receiver (3-bit)
//   - OVERSAMPLE / MID_SAMPLE sample-point constants
//   - calcDiv(): clock cycles per oversample tick, so TX and RX use the same timing
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 7;

    // Integer division truncates. A zero result would stall the divider, so it
    // is clamped to 1, which means one tick per clock.
    function automatic int unsigned calcDiv(input int unsigned clockRate,
                                            input int unsigned baudRate,
                                            input int unsigned oversample);
        int unsigned d;
        d = clockRate / (baudRate * oversample);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: free-running clock-enable generator at BAUD_RATE * OVERSAMPLE.
// Ports:
//   clk   in  board clock
//   rstN  in  asynchronous active-low reset
//   tick  out single-cycle enable, high when the divider count equals DIV-1
module uart_tick_gen
    import uart_pkg::calcDiv;
#(
    parameter int unsigned CLOCK_RATE = 27500000,
    parameter int unsigned BAUD_RATE  = 15625,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rstN,
    output logic tick
);

    localparam int unsigned DIV = calcDiv(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // With DIV = 1 the count stays at 0 = LAST, so tick is high every cycle.
    assign tick = (count == LAST);

endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 16x oversampling UART receiver with a one-entry
// valid/ready holding register.
// Ports:
//   clk        in   board clock
//   rstN       in   asynchronous active-low reset
//   rx         in   asynchronous serial input, idle high
//   rxReady    in   consumer accepts rxData when high with rxValid
//   rxData     out  received byte, LSB first
//   rxValid    out  holding register full
//   parityErr  out  1-cycle pulse at commit when parity mismatched
//   frameErr   out  1-cycle pulse at commit when the stop bit was low
//   overrun    out  1-cycle pulse when a completed byte is dropped
//   busy       out  FSM not idle
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 27500000,
    parameter int unsigned BAUD_RATE  = 15625,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 rx,
    input  logic                 rxReady,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxValid,
    output logic                 parityErr,
    output logic                 frameErr,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [3:0] MID_CNT  = 4'(MID_SAMPLE);
    localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic       ODD      = (PARITY_ODD != 0);
    localparam logic       HAS_PAR  = (PARITY_EN != 0);

    logic                 rxMeta;
    logic                 rxS;
    logic                 tick;
    logic [2:0]           state;
    logic [3:0]           sampleCnt;
    logic [2:0]           bitCnt;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 parityBit;
    logic                 armed;
    logic                 expParity;
    logic                 parityBad;

    uart_tick_gen #(
        .CLOCK_RATE (CLOCK_RATE),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) tickGen (
        .clk  (clk),
        .rstN (rstN),
        .tick (tick)
    );

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxS    <= rxMeta;
        end
    end

    assign expParity = (^shiftReg) ^ ODD;
    assign parityBad = HAS_PAR && (parityBit != expParity);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= ST_IDLE;
            sampleCnt <= '0;
            bitCnt    <= '0;
            shiftReg  <= '0;
            parityBit <= 1'b0;
            armed     <= 1'b1;
            rxData    <= '0;
            rxValid   <= 1'b0;
            parityErr <= 1'b0;
            frameErr  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            parityErr <= 1'b0;
            frameErr  <= 1'b0;
            overrun   <= 1'b0;
            if (rxValid && rxReady) begin
                rxValid <= 1'b0;
            end

            if (tick) begin
                case (state)
                    ST_IDLE: begin
                        if (armed && !rxS) begin
                            state     <= ST_START;
                            sampleCnt <= '0;
                        end else if (!armed && rxS) begin
                            armed <= 1'b1;
                        end
                    end
                    ST_START: begin
                        if (sampleCnt == MID_CNT) begin
                            if (!rxS) begin
                                state     <= ST_DATA;
                                sampleCnt <= '0;
                                bitCnt    <= '0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            sampleCnt <= sampleCnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        // 4-bit counter wraps 15 -> 0 naturally, so every
                        // later sample lands 16 ticks after the previous one.
                        sampleCnt <= sampleCnt + 1'b1;
                        if (sampleCnt == LAST_CNT) begin
                            shiftReg <= {rxS, shiftReg[DATA_BITS-1:1]};
                            bitCnt   <= bitCnt + 1'b1;
                            if (bitCnt == LAST_BIT) begin
                                state <= HAS_PAR ? ST_PARITY : ST_STOP;
                            end
                        end
                    end
                    ST_PARITY: begin
                        sampleCnt <= sampleCnt + 1'b1;
                        if (sampleCnt == LAST_CNT) begin
                            parityBit <= rxS;
                            state     <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        sampleCnt <= sampleCnt + 1'b1;
                        if (sampleCnt == LAST_CNT) begin
                            state <= ST_IDLE;
                            // A low stop bit may be a break; wait for the
                            // line to go high before accepting a new start.
                            if (!rxS) begin
                                armed <= 1'b0;
                            end
                            // Commit overrides the handshake clear above.
                            if (!rxValid || rxReady) begin
                                rxData  <= shiftReg;
                                rxValid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            parityErr <= parityBad;
                            frameErr  <= !rxS;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample. DIV = 1, so one bit = 16 clk.
module tb_uart_rx_oversample;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       rx = 1'b1;
    logic       rxReady = 1'b0;
    logic [7:0] rxData;
    logic       rxValid, parityErr, frameErr, overrun, busy;

    logic       rxP = 1'b1;
    logic       rxReadyP = 1'b1;
    logic [7:0] rxDataP;
    logic       rxValidP, parityErrP, frameErrP, overrunP, busyP;

    int unsigned nTests = 0;
    int unsigned nFail = 0;

    always #5 clk = ~clk;

    uart_rx_oversample #(
        .CLOCK_RATE (1600000),
        .BAUD_RATE  (100000),
        .DATA_BITS  (8),
        .PARITY_EN  (0),
        .PARITY_ODD (0)
    ) dutN (
        .clk       (clk),
        .rstN      (rstN),
        .rx        (rx),
        .rxReady   (rxReady),
        .rxData    (rxData),
        .rxValid   (rxValid),
        .parityErr (parityErr),
        .frameErr  (frameErr),
        .overrun   (overrun),
        .busy      (busy)
    );

    uart_rx_oversample #(
        .CLOCK_RATE (1600000),
        .BAUD_RATE  (100000),
        .DATA_BITS  (8),
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) dutP (
        .clk       (clk),
        .rstN      (rstN),
        .rx        (rxP),
        .rxReady   (rxReadyP),
        .rxData    (rxDataP),
        .rxValid   (rxValidP),
        .parityErr (parityErrP),
        .frameErr  (frameErrP),
        .overrun   (overrunP),
        .busy      (busyP)
    );

    // Observation counters, sampled on the falling edge.
    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int unsigned nRise = 0, nValHigh = 0, nPar = 0, nFrame = 0, nOver = 0, nBusy = 0;
    int unsigned riseCyc = 0;
    logic [7:0]  riseData = '0;
    logic        vPrev = 1'b0;
    int unsigned nRiseP = 0, nParP = 0, nFrameP = 0;
    logic [7:0]  riseDataP = '0;
    logic        vPrevP = 1'b0;

    always @(negedge clk) begin
        if (rxValid && !vPrev) begin
            nRise++;
            riseCyc  = cyc;
            riseData = rxData;
        end
        if (rxValid)   nValHigh++;
        if (parityErr) nPar++;
        if (frameErr)  nFrame++;
        if (overrun)   nOver++;
        if (busy)      nBusy++;
        vPrev = rxValid;
        if (rxValidP && !vPrevP) begin
            nRiseP++;
            riseDataP = rxDataP;
        end
        if (parityErrP) nParP++;
        if (frameErrP)  nFrameP++;
        vPrevP = rxValidP;
    end

    int unsigned bRise, bValHigh, bPar, bFrame, bOver, bBusy, bRiseP, bParP, bFrameP;
    int unsigned startCyc = 0;

    task automatic snap();
        bRise = nRise; bValHigh = nValHigh; bPar = nPar; bFrame = nFrame;
        bOver = nOver; bBusy = nBusy; bRiseP = nRiseP; bParP = nParP; bFrameP = nFrameP;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setRx(input bit usePar, input logic v);
        if (usePar) rxP = v;
        else        rx  = v;
    endtask

    // Called on a falling edge; returns on the falling edge ending the stop bit.
    task automatic sendFrame(input bit usePar, input logic [7:0] data,
                             input bit withPar, input bit parBit, input bit stopBit);
        setRx(usePar, 1'b0);
        startCyc = cyc;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            setRx(usePar, data[i]);
            repeat (16) @(negedge clk);
        end
        if (withPar) begin
            setRx(usePar, parBit);
            repeat (16) @(negedge clk);
        end
        setRx(usePar, stopBit);
        repeat (16) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(rxValid), 32'h0);
        check("rst_data",  32'(rxData), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_pulses", 32'({parityErr, frameErr, overrun}), 32'h0);
        rstN = 1'b1;
        rxReady = 1'b1;
        repeat (10) @(negedge clk);

        // 1: 8N1 0xA5, consumer ready
        snap();
        sendFrame(0, 8'hA5, 0, 0, 1);
        repeat (4) @(negedge clk);
        check("t1_rise",    nRise - bRise, 1);
        check("t1_data",    32'(riseData), 32'hA5);
        check("t1_latency", riseCyc - startCyc, 155);
        check("t1_vlen",    nValHigh - bValHigh, 1);
        check("t1_busy",    nBusy - bBusy, 152);
        check("t1_errs",    (nPar - bPar) + (nFrame - bFrame) + (nOver - bOver), 0);
        check("t1_vclr",    32'(rxValid), 32'h0);

        // 2: back-to-back with consumer stalled -> overrun, first byte kept
        rxReady = 1'b0;
        repeat (10) @(negedge clk);
        snap();
        sendFrame(0, 8'h3C, 0, 0, 1);
        check("t2_valid1", 32'(rxValid), 32'h1);
        check("t2_data1",  32'(rxData), 32'h3C);
        sendFrame(0, 8'hC3, 0, 0, 1);
        check("t2_over",   nOver - bOver, 1);
        check("t2_data2",  32'(rxData), 32'h3C);
        check("t2_valid2", 32'(rxValid), 32'h1);
        check("t2_rise",   nRise - bRise, 1);
        check("t2_ferr",   nFrame - bFrame, 0);
        rxReady = 1'b1;
        @(negedge clk);
        check("t2_clr",    32'(rxValid), 32'h0);
        repeat (10) @(negedge clk);

        // 3: 4-cycle glitch is a false start
        snap();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("t3_busy",   32'(busy), 32'h0);
        check("t3_bcnt",   nBusy - bBusy, 8);
        check("t3_rise",   nRise - bRise, 0);

        // 4: low stop bit, line then held low for 3 bit times
        rxReady = 1'b0;
        repeat (5) @(negedge clk);
        snap();
        sendFrame(0, 8'h55, 0, 0, 0);
        repeat (48) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("t4_valid",  32'(rxValid), 32'h1);
        check("t4_data",   32'(rxData), 32'h55);
        check("t4_ferr",   nFrame - bFrame, 1);
        check("t4_rise",   nRise - bRise, 1);
        check("t4_busy",   nBusy - bBusy, 152);
        rxReady = 1'b1;
        @(negedge clk);
        check("t4_clr",    32'(rxValid), 32'h0);
        snap();
        sendFrame(0, 8'h96, 0, 0, 1);
        repeat (4) @(negedge clk);
        check("t4_rearm",  32'(riseData), 32'h96);
        check("t4_ferr2",  nFrame - bFrame, 0);

        // 5: even parity, 0x07 has three ones so the correct parity bit is 1
        snap();
        sendFrame(1, 8'h07, 1, 0, 1);
        repeat (4) @(negedge clk);
        check("t5_perr",   nParP - bParP, 1);
        check("t5_data",   32'(riseDataP), 32'h07);
        check("t5_ferr",   nFrameP - bFrameP, 0);
        snap();
        sendFrame(1, 8'h07, 1, 1, 1);
        repeat (4) @(negedge clk);
        check("t5_pok",    nParP - bParP, 0);
        check("t5_rise",   nRiseP - bRiseP, 1);

        // 6: reset in the middle of data bit 4 of 0xFF
        repeat (10) @(negedge clk);
        snap();
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (72) @(negedge clk);
        check("t6_busy_pre", 32'(busy), 32'h1);
        rstN = 1'b0;
        #1;
        check("t6_rst_busy",  32'(busy), 32'h0);
        check("t6_rst_data",  32'(rxData), 32'h0);
        check("t6_rst_valid", 32'(rxValid), 32'h0);
        check("t6_rst_puls",  32'({parityErr, frameErr, overrun}), 32'h0);
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (40) @(negedge clk);
        check("t6_nopulse", (nPar - bPar) + (nFrame - bFrame) + (nOver - bOver) + (nRise - bRise), 0);
        sendFrame(0, 8'h81, 0, 0, 1);
        repeat (4) @(negedge clk);
        check("t6_rise",   nRise - bRise, 1);
        check("t6_data",   32'(riseData), 32'h81);
        check("t6_errs",   (nPar - bPar) + (nFrame - bFrame) + (nOver - bOver), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
UART receiver, the receive end of the serial link whose bit timing comes from the board baud generator. It recovers 8N1 or 8-bit-plus-parity frames from the asynchronous `rx` pin using 16x oversampling, driven by an internal clock-enable tick rather than a derived clock. Received bytes are presented on a one-entry valid/ready holding register with sticky-free error pulses. It sits between the board RX pin and the lab's byte consumer (echo/command logic).

Parameters:
- `CLOCK_RATE`, 27500000: board clock frequency, Hz.
- `BAUD_RATE`, 15625: serial bit rate.
- `DATA_BITS`, 8: data bits per frame, 5..8, LSB first.
- `PARITY_EN`, 0: 1 = one parity bit follows the data bits.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even; ignored if `PARITY_EN` = 0.

Ports:
- `clk`  in  1  board clock.
- `rstN`  in  1  asynchronous active-low reset.
- `rx`  in  1  serial input, asynchronous, idle high.
- `rxReady`  in  1  consumer accepts `rxData` when high together with `rxValid`.
- `rxData`  out  `DATA_BITS`  received byte, zero-extended LSB first.
- `rxValid`  out  1  holding register full.
- `parityErr`  out  1  1-cycle pulse with byte load when parity mismatched.
- `frameErr`  out  1  1-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1  1-cycle pulse when a completed byte is dropped.
- `busy`  out  1  high in any state other than IDLE.

Behaviour:
- Reset (`rstN` low, asynchronous):
  - State = IDLE; counters = 0; synchronizer flops = 1.
  - `rxData` = 0; `rxValid`, `parityErr`, `frameErr`, `overrun`, `busy` = 0.
  - The armed flag = 1.
  - Reset mid-frame discards the partial frame; no pulses are emitted.
- Synchronizer:
  - `rx` passes through 2 flops; all logic uses the synchronized value `rxS`.
  - This adds 2 cycles of latency.
- Tick generator:
  - `DIV` = `CLOCK_RATE` / (`BAUD_RATE` * 16), integer division; 110 at the defaults.
  - The counter runs 0..`DIV`-1 free-running, and `tick` = 1 for the single cycle where the count equals `DIV`-1.
  - `DIV` = 1 gives `tick` = 1 every cycle.
  - Width = `$clog2(DIV)`, minimum 1.
- `sampleCnt` is 4 bits and advances only on `tick`.
- FSM transitions are evaluated only on `tick` cycles:
  - IDLE: if armed and `rxS` = 0, go to START with `sampleCnt` = 0. If not armed, set armed = 1 when `rxS` = 1.
  - START: increment `sampleCnt`. At `sampleCnt` = 7 (mid start bit):
    - `rxS` = 0: go to DATA with `sampleCnt` = 0 and `bitCnt` = 0.
    - otherwise: false start, return to IDLE.
  - DATA: at `sampleCnt` = 15, shift `rxS` into the MSB of the shift register (right shift), then `bitCnt`++. After `DATA_BITS` samples, go to PARITY if `PARITY_EN`, else STOP; `sampleCnt` wraps to 0.
  - PARITY: at `sampleCnt` = 15, latch the parity bit, then go to STOP.
  - STOP: at `sampleCnt` = 15, sample the stop bit, perform the frame commit, then go to IDLE. The next start bit is detectable from the following tick.
    - If the stop bit is 0, clear armed, so a break or low line cannot retrigger until `rx` is seen high.
- Parity check: expected = XOR of the data bits, inverted if `PARITY_ODD`; a mismatch with the received parity bit sets `parityErr`.
- Frame commit (the cycle after the STOP sample tick, registered), in priority order:
  1. `rxValid` = 0, or `rxValid` = 1 with `rxReady` = 1 in the same cycle: load `rxData`, set `rxValid` = 1, pulse `parityErr`/`frameErr` as applicable.
  2. Otherwise: keep the old byte and pulse `overrun`. The error pulses still fire.
- Handshake:
  - `rxValid` clears on the cycle after `rxValid` && `rxReady`, unless a commit reloads it that cycle.
  - `rxData` is stable while `rxValid` = 1.
- Latency: `rxValid` rises 1 `clk` after the stop-bit mid-sample tick, plus 2 synchronizer cycles relative to the pin.
- `busy` = (state != IDLE).

Decomposition:
- Shared package `uart_pkg` holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP, 3-bit);
  - `OVERSAMPLE` = 16 and `MID_SAMPLE` = 7;
  - the `DIV` computation function, so the transmitter uses identical timing.
- Natural sub-module: `uart_tick_gen`, with params `CLOCK_RATE`, `BAUD_RATE`, `OVERSAMPLE`, ports `clk`, `rstN`, `tick`. Instantiate it once in this block.

Test Plan:
Bench uses `CLOCK_RATE` = 1600000 and `BAUD_RATE` = 100000, so `DIV` = 1 and 1 bit = 16 `clk`.
1. 8N1, send 0xA5 with `rxReady` held 1 → `rxValid` pulses high for 1 cycle with `rxData` = 0xA5, no error pulses, `busy` high for ~9.5 bit times.
2. Send 0x3C then 0xC3 back-to-back with `rxReady` = 0 → first `rxValid` = 1 with 0x3C held; at the second commit `overrun` pulses and `rxData` stays 0x3C. Asserting `rxReady` then clears `rxValid`.
3. Glitch: `rx` low for 4 `clk` then high → FSM returns to IDLE at the mid-start check; no `rxValid`, `busy` drops.
4. Stop bit forced 0, data 0x55 → `rxData` = 0x55, `rxValid` = 1, `frameErr` 1-cycle pulse. Holding `rx` low for 3 bit times produces no new frame until `rx` returns high.
5. `PARITY_EN` = 1, `PARITY_ODD` = 0, send 0x07 with parity bit 0 (wrong) → `parityErr` pulses. Resending with parity 1 → no pulse.
6. Assert `rstN` = 0 during data bit 4 of 0xFF → all outputs 0 immediately. After release, a fresh 0x81 is received correctly.
